// File: rtl/compare_seq.sv
`default_nettype none
// ============================================================================
//  Module      : compare_seq
//  Description : Multi-cycle magnitude comparator. Scans both operands
//                CHUNK bits per cycle from the MSB down and reports EQ/NE/LT/
//                LE/GT/GE plus {gt,lt,eq} flags after a fixed N+1 cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module compare_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic             sgn,
    input  logic [WIDTH-1:0] R1,
    input  logic [WIDTH-1:0] R2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] RD,
    output logic [2:0]       flags,
    output logic             err
);

    localparam int              N      = WIDTH / CHUNK;
    localparam int              CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   c_last = CW'(N - 1);
    localparam logic [WIDTH-1:0] c_msb = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_gt;
    logic             r_lt;
    logic [WIDTH-1:0] r_rd;
    logic [2:0]       r_flags;
    logic             r_err;

    logic [WIDTH-1:0] w_a_cap;
    logic [WIDTH-1:0] w_b_cap;
    logic [CHUNK-1:0] w_sa;
    logic [CHUNK-1:0] w_sb;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;
    logic             w_rel;
    logic             w_ill;
    logic             w_last;

    // Flipping the sign bit maps two's complement onto offset binary, so the
    // unsigned slice scan orders signed operands correctly.
    assign w_a_cap = R1 ^ (sgn ? c_msb : '0);
    assign w_b_cap = R2 ^ (sgn ? c_msb : '0);

    // Operands shift left each RUN cycle, so the slice under test is always the top one.
    assign w_sa = r_a[WIDTH-1 -: CHUNK];
    assign w_sb = r_b[WIDTH-1 -: CHUNK];

    assign w_gt   = r_gt | (~r_gt & ~r_lt & (w_sa > w_sb));
    assign w_lt   = r_lt | (~r_gt & ~r_lt & (w_sa < w_sb));
    assign w_eq   = ~w_gt & ~w_lt;
    assign w_last = (r_state == S_RUN) && (r_cnt == c_last);

    always_comb begin
        w_rel = 1'b0;
        w_ill = 1'b0;
        case (r_op)
            3'b000:  w_rel = w_eq;
            3'b001:  w_rel = ~w_eq;
            3'b010:  w_rel = w_lt;
            3'b011:  w_rel = w_lt | w_eq;
            3'b100:  w_rel = w_gt;
            3'b101:  w_rel = w_gt | w_eq;
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == c_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_rd    <= '0;
            r_flags <= '0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_a   <= w_a_cap;
                r_b   <= w_b_cap;
                r_op  <= opcode;
                r_cnt <= '0;
                r_gt  <= 1'b0;
                r_lt  <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_a   <= r_a << CHUNK;
                r_b   <= r_b << CHUNK;
                r_cnt <= r_cnt + CW'(1);
                r_gt  <= w_gt;
                r_lt  <= w_lt;
            end
            // Results change only on entry to DONE and hold until the next one.
            if (w_last) begin
                r_flags <= {w_gt, w_lt, w_eq};
                r_rd    <= WIDTH'(w_rel);
                r_err   <= w_ill;
            end
        end
    end

    assign RD    = r_rd;
    assign flags = r_flags;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: doc/compare_seq.md
COMPARE_SEQ -- requirements
Module: compare_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 2: operand bits examined per RUN cycle; WIDTH SHALL be an integer multiple of CHUNK, with N = WIDTH/CHUNK.
REQ-003 Port Clk  in  1  system clock; all state changes on rising edge.
REQ-004 Port Rst  in  1  reset, asynchronous, active-high.
REQ-005 Port start  in  1  request a compare; sampled only in IDLE.
REQ-006 Port opcode  in  3  compare select: 000 EQ, 001 NE, 010 LT, 011 LE, 100 GT, 101 GE, 110/111 illegal.
REQ-007 Port sgn  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 Port R1  in  WIDTH  first operand.
REQ-009 Port R2  in  WIDTH  second operand.
REQ-010 Port busy  out  1  high in RUN and DONE.
REQ-011 Port done  out  1  one-cycle completion pulse.
REQ-012 Port RD  out  WIDTH  result: 1 (zero-extended) if the relation holds, else 0.
REQ-013 Port flags  out  3  {gt, lt, eq} of R1 versus R2.
REQ-014 Port err  out  1  high when the completed operation had an illegal opcode.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; all transitions on the rising edge of Clk.
REQ-016 IDLE with start=1 SHALL capture R1, R2, opcode and sgn into internal registers, clear the chunk counter and decision, and enter RUN; IDLE with start=0 SHALL stay in IDLE.
REQ-017 When sgn=1, capture SHALL invert the MSB of both operands (offset-binary), so the unsigned scan yields the signed ordering.
REQ-018 RUN SHALL last exactly N cycles, examining one CHUNK-bit slice per cycle from the most significant slice down.
REQ-019 The first slice with unequal values SHALL latch the decision (gt or lt); later slices SHALL NOT alter a latched decision.
REQ-020 If no slice differs after N cycles, the decision SHALL be eq.
REQ-021 After the Nth RUN cycle the FSM SHALL enter DONE and in the same edge load flags, RD and err; DONE SHALL last one cycle, then return to IDLE.
REQ-022 done SHALL be high only in DONE, i.e. exactly N+1 rising edges after the edge that sampled start.
REQ-023 Total latency SHALL be fixed at N+1 cycles regardless of operand values; minimum start-to-start spacing SHALL be N+2 cycles.
REQ-024 start during RUN or DONE SHALL be ignored; input changes during RUN or DONE SHALL NOT affect the operation in progress.
REQ-025 For an illegal opcode: RD=0, err=1, and flags SHALL still report the true comparison.
REQ-026 For a legal opcode: err=0.
REQ-027 RD, flags and err SHALL hold their values from DONE until the next DONE or reset.
REQ-028 flags SHALL be one-hot after any completed operation.

Reset
REQ-029 Rst=1 SHALL immediately, without waiting for Clk, force IDLE, busy=0, done=0, RD=0, flags=000, err=0, and clear the counter, decision and captured operands.
REQ-030 Rst asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start after Rst deasserts SHALL behave as from power-up.

Verification
REQ-031 WIDTH=8, CHUNK=2, sgn=0, opcode=010, R1=8'h12, R2=8'h34, start one cycle -> busy high 5 cycles, done pulse at edge 5, RD=1, flags=010, err=0.
REQ-032 sgn=1, opcode=100, R1=8'hFF (-1), R2=8'h01 -> RD=0, flags=010; same operands with sgn=0 -> RD=1, flags=100.
REQ-033 opcode=000, R1=R2=8'hA5 -> RD=1, flags=001, after exactly 5 cycles; opcode=001 with the same operands -> RD=0.
REQ-034 R1=8'h80, R2=8'h7F, sgn=0, opcode=101, with R1 changed to 8'h00 and start pulsed again during RUN -> single done, RD=1, flags=100, second start ignored.
REQ-035 Rst pulsed asynchronously (between Clk edges) at RUN cycle 2 -> all outputs 0 immediately, no done pulse; a new start then completes normally in 5 cycles.
REQ-036 opcode=111, R1=8'h01, R2=8'h02 -> RD=0, err=1, flags=010; RD, flags and err then held for 10 idle cycles.
